// File: rtl/soc_map_pkg.sv
// SoC address map shared by the CPU top, the data SRAM responder and the testbench.
package soc_map_pkg;

  localparam logic [15:0] CONF_HI     = 16'hBFAF;

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SW      = 16'hF004;
  localparam logic [15:0] OFF_SCRATCH = 16'hF008;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;

  localparam logic [15:0] LED_RST     = 16'h0000;
  localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;
  localparam logic [31:0] TIMER_RST   = 32'h0000_0000;
  localparam logic [31:0] RDATA_RST   = 32'h0000_0000;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_CONF
  } rd_src_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = we[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_sp_be.sv
// Single-port RAM, 4 byte lanes, synchronous read; 1-cycle latency, always ready.
// Output register only updates on read cycles so it holds across writes and idles.
module bram_sp_be #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      if (we_i == 4'b0000) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// CPU data-port target: RAM plus LED/switch/scratch/timer registers, read data 1 cycle after request.
// No backpressure: every request completes; rdata holds on write and idle cycles.
module data_sram_responder #(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] CONF_HI = soc_map_pkg::CONF_HI,
  parameter int          SW_W    = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            data_sram_en,
  input  logic [3:0]      data_sram_we,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic [31:0]     data_sram_rdata,
  output logic [15:0]     led,
  input  logic [SW_W-1:0] switch
);
  import soc_map_pkg::*;

  logic        is_conf, rd_req, conf_wr;
  logic [15:0] off;
  logic [31:0] ram_rdata, conf_val;
  logic        unused_addr_lsb;

  logic [15:0]     led_q, led_d;
  logic [31:0]     scratch_q, scratch_d;
  logic [31:0]     timer_q, timer_d;
  logic [31:0]     conf_rdata_q;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  rd_src_e         rd_src_q;

  assign is_conf         = (data_sram_addr[31:16] == CONF_HI);
  assign off             = {data_sram_addr[15:2], 2'b00};
  assign rd_req          = data_sram_en && (data_sram_we == 4'b0000);
  assign conf_wr         = data_sram_en && is_conf && (data_sram_we != 4'b0000);
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  bram_sp_be #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .en_i    (data_sram_en && !is_conf),
    .we_i    (data_sram_we),
    .addr_i  (data_sram_addr[RAM_AW+1:2]),
    .wdata_i (data_sram_wdata),
    .rdata_o (ram_rdata)
  );

  // A timer write replaces that cycle's increment with the merged value.
  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'd1;
    if (conf_wr) begin
      case (off)
        OFF_LED: begin
          led_d[15:8] = data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8];
          led_d[7:0]  = data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0];
        end
        OFF_SCRATCH: scratch_d = merge_lanes(scratch_q, data_sram_wdata, data_sram_we);
        OFF_TIMER:   timer_d   = merge_lanes(timer_q, data_sram_wdata, data_sram_we);
        default:     ;
      endcase
    end
  end

  always_comb begin
    case (off)
      OFF_LED:     conf_val = {16'h0000, led_q};
      OFF_SW:      conf_val = 32'(sw_sync_q);
      OFF_SCRATCH: conf_val = scratch_q;
      OFF_TIMER:   conf_val = timer_q;
      default:     conf_val = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q        <= LED_RST;
      scratch_q    <= SCRATCH_RST;
      timer_q      <= TIMER_RST;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      conf_rdata_q <= RDATA_RST;
      rd_src_q     <= SRC_NONE;
    end else begin
      led_q     <= led_d;
      scratch_q <= scratch_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      if (rd_req) begin
        rd_src_q <= is_conf ? SRC_CONF : SRC_RAM;
        if (is_conf) conf_rdata_q <= conf_val;
      end
    end
  end

  // SRC_NONE covers the window after reset, before any read has completed.
  always_comb begin
    case (rd_src_q)
      SRC_RAM:  data_sram_rdata = ram_rdata;
      SRC_CONF: data_sram_rdata = conf_rdata_q;
      default:  data_sram_rdata = RDATA_RST;
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM, byte lanes, config registers, timer and reset.
module tb_data_sram_responder;
  import soc_map_pkg::*;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch;

  int n_chk;
  int n_fail;

  localparam logic [31:0] A_LED     = {CONF_HI, OFF_LED};
  localparam logic [31:0] A_SW      = {CONF_HI, OFF_SW};
  localparam logic [31:0] A_SCRATCH = {CONF_HI, OFF_SCRATCH};
  localparam logic [31:0] A_TIMER   = {CONF_HI, OFF_TIMER};

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .switch          (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; results are observed on the next falling edge.
  task automatic rd(input logic [31:0] a);
    data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = a; data_sram_wdata = 32'h0;
    @(negedge clk);
    data_sram_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    data_sram_en = 1'b1; data_sram_we = we; data_sram_addr = a; data_sram_wdata = d;
    @(negedge clk);
    data_sram_en = 1'b0; data_sram_we = 4'h0;
  endtask

  task automatic idle(input int n);
    data_sram_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_we = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0; switch = 8'h00;
    repeat (2) @(negedge clk);
    n_chk++; if (data_sram_rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h want %h", data_sram_rdata, 32'h0); n_fail++; end
    n_chk++; if (led !== 16'h0) begin $display("FAIL reset_led: got %h want %h", led, 16'h0); n_fail++; end
    resetn = 1'b1;
    rd(A_TIMER);
    n_chk++; if (data_sram_rdata !== 32'h0) begin $display("FAIL timer_first: got %h want %h", data_sram_rdata, 32'h0); n_fail++; end
    rd(A_TIMER);
    n_chk++; if (data_sram_rdata !== 32'h1) begin $display("FAIL timer_second: got %h want %h", data_sram_rdata, 32'h1); n_fail++; end
    idle(1);
    n_chk++; if (data_sram_rdata !== 32'h1) begin $display("FAIL idle_hold: got %h want %h", data_sram_rdata, 32'h1); n_fail++; end
  endtask

  task automatic test_ram;
    wr(4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    n_chk++; if (data_sram_rdata !== 32'h1) begin $display("FAIL write_hold: got %h want %h", data_sram_rdata, 32'h1); n_fail++; end
    rd(32'h0000_0010);
    n_chk++; if (data_sram_rdata !== 32'hDEAD_BEEF) begin $display("FAIL ram_raw: got %h want %h", data_sram_rdata, 32'hDEAD_BEEF); n_fail++; end
    rd(32'h0001_0010);
    n_chk++; if (data_sram_rdata !== 32'hDEAD_BEEF) begin $display("FAIL ram_alias: got %h want %h", data_sram_rdata, 32'hDEAD_BEEF); n_fail++; end
    wr(4'b0101, 32'h0000_0010, 32'h1122_3344);
    rd(32'h0000_0010);
    n_chk++; if (data_sram_rdata !== 32'hDE22_BE44) begin $display("FAIL ram_lanes: got %h want %h", data_sram_rdata, 32'hDE22_BE44); n_fail++; end
  endtask

  task automatic test_back_to_back;
    wr(4'hF, 32'h0000_0020, 32'hAAAA_5555);
    wr(4'hF, 32'h0000_0024, 32'h1234_5678);
    rd(32'h0000_0020);
    n_chk++; if (data_sram_rdata !== 32'hAAAA_5555) begin $display("FAIL b2b_0: got %h want %h", data_sram_rdata, 32'hAAAA_5555); n_fail++; end
    rd(32'h0000_0024);
    n_chk++; if (data_sram_rdata !== 32'h1234_5678) begin $display("FAIL b2b_1: got %h want %h", data_sram_rdata, 32'h1234_5678); n_fail++; end
  endtask

  task automatic test_led;
    wr(4'hF, A_LED, 32'h0001_A5A5);
    n_chk++; if (led !== 16'hA5A5) begin $display("FAIL led_out: got %h want %h", led, 16'hA5A5); n_fail++; end
    rd(A_LED);
    n_chk++; if (data_sram_rdata !== 32'h0000_A5A5) begin $display("FAIL led_rd: got %h want %h", data_sram_rdata, 32'h0000_A5A5); n_fail++; end
    wr(4'b0010, A_LED, 32'h0000_3C00);
    n_chk++; if (led !== 16'h3CA5) begin $display("FAIL led_lane: got %h want %h", led, 16'h3CA5); n_fail++; end
    rd(32'h0000_0024);
    rd(A_LED);
    n_chk++; if (data_sram_rdata !== 32'h0000_3CA5) begin $display("FAIL led_after_ram: got %h want %h", data_sram_rdata, 32'h0000_3CA5); n_fail++; end
  endtask

  task automatic test_scratch;
    wr(4'hF, A_SCRATCH, 32'hCAFE_F00D);
    wr(4'b1000, A_SCRATCH, 32'h1200_0000);
    rd(A_SCRATCH);
    n_chk++; if (data_sram_rdata !== 32'h12FE_F00D) begin $display("FAIL scratch: got %h want %h", data_sram_rdata, 32'h12FE_F00D); n_fail++; end
  endtask

  task automatic test_switch;
    switch = 8'h3C;
    idle(3);
    rd(A_SW);
    n_chk++; if (data_sram_rdata !== 32'h0000_003C) begin $display("FAIL sw_rd: got %h want %h", data_sram_rdata, 32'h0000_003C); n_fail++; end
    wr(4'hF, A_SW, 32'hFFFF_FFFF);
    rd(A_SW);
    n_chk++; if (data_sram_rdata !== 32'h0000_003C) begin $display("FAIL sw_ro: got %h want %h", data_sram_rdata, 32'h0000_003C); n_fail++; end
    rd({CONF_HI, 16'hF00C});
    n_chk++; if (data_sram_rdata !== 32'h0) begin $display("FAIL unmapped: got %h want %h", data_sram_rdata, 32'h0); n_fail++; end
    rd({CONF_HI, 16'hF006});
    n_chk++; if (data_sram_rdata !== 32'h0000_003C) begin $display("FAIL sw_lsb_ignored: got %h want %h", data_sram_rdata, 32'h0000_003C); n_fail++; end
  endtask

  task automatic test_timer;
    wr(4'hF, A_TIMER, 32'hFFFF_FFFE);
    rd(A_TIMER);
    n_chk++; if (data_sram_rdata !== 32'hFFFF_FFFE) begin $display("FAIL timer_load: got %h want %h", data_sram_rdata, 32'hFFFF_FFFE); n_fail++; end
    rd(A_TIMER);
    n_chk++; if (data_sram_rdata !== 32'hFFFF_FFFF) begin $display("FAIL timer_max: got %h want %h", data_sram_rdata, 32'hFFFF_FFFF); n_fail++; end
    rd(A_TIMER);
    n_chk++; if (data_sram_rdata !== 32'h0) begin $display("FAIL timer_wrap: got %h want %h", data_sram_rdata, 32'h0); n_fail++; end
    rd(A_TIMER);
    n_chk++; if (data_sram_rdata !== 32'h1) begin $display("FAIL timer_post_wrap: got %h want %h", data_sram_rdata, 32'h1); n_fail++; end
    wr(4'hF, A_TIMER, 32'h0000_0100);
    wr(4'b0001, A_TIMER, 32'h0000_00AA);
    rd(A_TIMER);
    n_chk++; if (data_sram_rdata !== 32'h0000_01AA) begin $display("FAIL timer_merge: got %h want %h", data_sram_rdata, 32'h0000_01AA); n_fail++; end
  endtask

  task automatic test_reset_mid;
    data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = A_TIMER;
    resetn = 1'b0;
    #1;
    n_chk++; if (data_sram_rdata !== 32'h0) begin $display("FAIL midreset_rdata: got %h want %h", data_sram_rdata, 32'h0); n_fail++; end
    n_chk++; if (led !== 16'h0) begin $display("FAIL midreset_led: got %h want %h", led, 16'h0); n_fail++; end
    @(negedge clk);
    data_sram_en = 1'b0;
    resetn = 1'b1;
    idle(2);
    n_chk++; if (data_sram_rdata !== 32'h0) begin $display("FAIL post_reset_hold: got %h want %h", data_sram_rdata, 32'h0); n_fail++; end
    rd(32'h0000_0010);
    n_chk++; if (data_sram_rdata !== 32'hDE22_BE44) begin $display("FAIL ram_retained: got %h want %h", data_sram_rdata, 32'hDE22_BE44); n_fail++; end
    rd(A_SCRATCH);
    n_chk++; if (data_sram_rdata !== 32'h0) begin $display("FAIL scratch_reset: got %h want %h", data_sram_rdata, 32'h0); n_fail++; end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_ram();
    test_back_to_back();
    test_led();
    test_scratch();
    test_switch();
    test_timer();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
